branch_prediction_controller: RTL

//  Next-generation branch/jump unit: direct-mapped BTB with per-entry saturating counters predicts at IF;

---
 rtl/bp_pkg.sv | 34 +++
 rtl/branch_prediction_controller_if.sv | 55 +++++
 rtl/branch_cond_eval.sv | 35 +++
 rtl/branch_prediction_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared constants and helpers for the branch prediction controller.
//   FUNC3_*        : RISC-V B-type funct3 encodings used by the condition eval
//   CTR_WEAK_T     : saturating counter value "weakly taken"     (10..0)
//   CTR_WEAK_NT    : saturating counter value "weakly not-taken" (01..1)
//   CTR_STRONG_T   : saturating counter value "strongly taken"   (11..1)
// Counter helpers return a 32-bit value; callers cast to their counter width.
// ---------------------------------------------------------------------------
package bp_pkg;

  localparam logic [2:0] FUNC3_BEQ  = 3'b000;
  localparam logic [2:0] FUNC3_BNE  = 3'b001;
  localparam logic [2:0] FUNC3_BLT  = 3'b100;
  localparam logic [2:0] FUNC3_BGE  = 3'b101;
  localparam logic [2:0] FUNC3_BLTU = 3'b110;
  localparam logic [2:0] FUNC3_BGEU = 3'b111;

  // MSB set, all lower bits clear
  function automatic logic [31:0] CTR_WEAK_T(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // MSB clear, all lower bits set
  function automatic logic [31:0] CTR_WEAK_NT(input int unsigned w);
    return CTR_WEAK_T(w) - 32'd1;
  endfunction

  // All w bits set
  function automatic logic [31:0] CTR_STRONG_T(input int unsigned w);
    return 32'hFFFF_FFFF >> (32'd32 - w);
  endfunction

endpackage

// File: rtl/branch_prediction_controller_if.sv
// ---------------------------------------------------------------------------
// branch_prediction_controller_if
// Bundles the fetch-side prediction signals, the EX-side resolution signals
// and the redirect/statistics outputs of the branch prediction controller.
//   master : pipeline side (drives if_pc and ex_*, consumes predictions,
//            redirect and counters)
//   slave  : the branch prediction controller
// ---------------------------------------------------------------------------
interface branch_prediction_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);

  // Fetch side
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;

  // Execute side
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_branch;
  logic              ex_jump;
  logic [2:0]        ex_func3;
  logic              ex_zero;
  logic              ex_sign;
  logic              ex_sltu;
  logic [ADDR_W-1:0] ex_branch_target;
  logic [ADDR_W-1:0] ex_jump_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;

  // Redirect and statistics
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_func3,
           ex_zero, ex_sign, ex_sltu, ex_branch_target, ex_jump_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_branch, ex_jump, ex_func3,
           ex_zero, ex_sign, ex_sltu, ex_branch_target, ex_jump_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect_valid, redirect_pc,
           branch_count, mispredict_count
  );

endinterface

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Combinational B-type outcome from funct3 and the ALU flags of rs1-rs2.
//   func3 : funct3 of the branch
//   zero  : rs1 == rs2
//   sign  : signed rs1 < rs2 (only meaningful when zero is clear)
//   sltu  : unsigned rs1 < rs2 (only meaningful when zero is clear)
//   taken : branch condition holds
// Reserved encodings 010/011 are treated as never taken.
// ---------------------------------------------------------------------------
module branch_cond_eval
  import bp_pkg::*;
(
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       sign,
  input  logic       sltu,
  output logic       taken
);

  // Decode funct3 into the taken condition
  always_comb begin
    taken = 1'b0;
    case (func3)
      FUNC3_BEQ:  taken = zero;
      FUNC3_BNE:  taken = ~zero;
      FUNC3_BLT:  taken = sign & ~zero;
      FUNC3_BGE:  taken = ~sign;
      FUNC3_BLTU: taken = sltu & ~zero;
      FUNC3_BGEU: taken = ~sltu;
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_prediction_controller.sv
// ---------------------------------------------------------------------------
// branch_prediction_controller
// Direct-mapped BTB with per-entry saturating counters. Predicts at IF,
// resolves B-type/JAL at EX, detects mispredicts, trains the tables and
// issues a one-cycle registered redirect to the PC mux.
// Ports:
//   CLK   : clock, rising edge
//   RESET : asynchronous active-low reset
//   bus   : branch_prediction_controller_if.slave
//           (if_pc -> pred_taken/pred_target, combinational from table state;
//            ex_* resolution inputs;
//            redirect_valid/redirect_pc, branch_count/mispredict_count, registered)
// ---------------------------------------------------------------------------
module branch_prediction_controller
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CTR_W       = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                           CLK,
  input  logic                           RESET,
  branch_prediction_controller_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);
  localparam logic [CTR_W-1:0]  CTR_WT   = CTR_W'(CTR_WEAK_T(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_WNT  = CTR_W'(CTR_WEAK_NT(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_ST   = CTR_W'(CTR_STRONG_T(CTR_W));
  localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CTR_ONE  = CTR_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(32'd1);

  // Table state
  logic              btb_valid_r  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_r    [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_target_r [BTB_ENTRIES];
  logic [CTR_W-1:0]  btb_ctr_r    [BTB_ENTRIES];

  // Output registers
  logic              redirect_valid_r;
  logic [ADDR_W-1:0] redirect_pc_r;
  logic [CNT_W-1:0]  branch_count_r;
  logic [CNT_W-1:0]  mispredict_count_r;

  // Fetch lookup
  logic [IDX_W-1:0]  if_idx_s;
  logic [TAG_W-1:0]  if_tag_s;
  logic              if_hit_s;
  logic              pred_taken_s;
  logic [ADDR_W-1:0] pred_target_s;

  // Resolution
  logic [IDX_W-1:0]  ex_idx_s;
  logic [TAG_W-1:0]  ex_tag_s;
  logic              cond_taken_s;
  logic              resolve_s;
  logic              taken_s;
  logic [ADDR_W-1:0] target_s;
  logic [ADDR_W-1:0] actual_next_s;
  logic              mispredict_s;

  // Training
  logic              ex_hit_s;
  logic [CTR_W-1:0]  cur_ctr_s;
  logic              upd_en_s;
  logic [ADDR_W-1:0] upd_target_s;
  logic [CTR_W-1:0]  upd_ctr_s;

  assign if_idx_s = bus.if_pc[IDX_W+1:2];
  assign if_tag_s = bus.if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx_s = bus.ex_pc[IDX_W+1:2];
  assign ex_tag_s = bus.ex_pc[ADDR_W-1:IDX_W+2];

  branch_cond_eval u_cond (
    .func3 (bus.ex_func3),
    .zero  (bus.ex_zero),
    .sign  (bus.ex_sign),
    .sltu  (bus.ex_sltu),
    .taken (cond_taken_s)
  );

  // Fetch-side prediction; reads pre-update table state (no bypass)
  always_comb begin
    if_hit_s     = btb_valid_r[if_idx_s] && (btb_tag_r[if_idx_s] == if_tag_s);
    pred_taken_s = if_hit_s & btb_ctr_r[if_idx_s][CTR_W-1];
    if (pred_taken_s) begin
      pred_target_s = btb_target_r[if_idx_s];
    end else begin
      pred_target_s = bus.if_pc + PC_STEP;
    end
  end

  // EX-side outcome and mispredict detection; an instruction in EX while a
  // redirect is being issued is on the wrong path and never resolves
  always_comb begin
    resolve_s = bus.ex_valid & (bus.ex_branch | bus.ex_jump) & ~redirect_valid_r;
    if (bus.ex_jump) begin
      taken_s  = 1'b1;
      target_s = bus.ex_jump_target;
    end else begin
      taken_s  = cond_taken_s;
      target_s = bus.ex_branch_target;
    end
    if (taken_s) begin
      actual_next_s = target_s;
    end else begin
      actual_next_s = bus.ex_pc + PC_STEP;
    end
    // a not-taken outcome never looks at the predicted target
    mispredict_s = (taken_s != bus.ex_pred_taken) |
                   (taken_s & (target_s != bus.ex_pred_target));
  end

  // Compute the table entry written back on a resolve event
  always_comb begin
    ex_hit_s     = btb_valid_r[ex_idx_s] && (btb_tag_r[ex_idx_s] == ex_tag_s);
    cur_ctr_s    = btb_ctr_r[ex_idx_s];
    upd_en_s     = 1'b0;
    upd_target_s = btb_target_r[ex_idx_s];
    upd_ctr_s    = cur_ctr_s;
    if (!resolve_s) begin
      upd_en_s = 1'b0;
    end else if (bus.ex_jump) begin
      upd_en_s     = 1'b1;
      upd_target_s = bus.ex_jump_target;
      upd_ctr_s    = CTR_ST;
    end else if (ex_hit_s) begin
      upd_en_s = 1'b1;
      if (cond_taken_s) begin
        upd_target_s = bus.ex_branch_target;
        if (cur_ctr_s != CTR_ST) begin
          upd_ctr_s = cur_ctr_s + CTR_ONE;
        end else begin
          upd_ctr_s = cur_ctr_s;
        end
      end else begin
        upd_target_s = btb_target_r[ex_idx_s];
        if (cur_ctr_s != CTR_ZERO) begin
          upd_ctr_s = cur_ctr_s - CTR_ONE;
        end else begin
          upd_ctr_s = cur_ctr_s;
        end
      end
    end else if (cond_taken_s) begin
      upd_en_s     = 1'b1;
      upd_target_s = bus.ex_branch_target;
      upd_ctr_s    = CTR_WT;
    end else begin
      // not-taken miss: nothing worth remembering
      upd_en_s = 1'b0;
    end
  end

  // BTB storage: reset clears valids and parks counters at weakly not-taken
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= {TAG_W{1'b0}};
        btb_target_r[i] <= {ADDR_W{1'b0}};
        btb_ctr_r[i]    <= CTR_WNT;
      end
    end else if (upd_en_s) begin
      btb_valid_r[ex_idx_s]  <= 1'b1;
      btb_tag_r[ex_idx_s]    <= ex_tag_s;
      btb_target_r[ex_idx_s] <= upd_target_s;
      btb_ctr_r[ex_idx_s]    <= upd_ctr_s;
    end
  end

  // Redirect pulse and saturating statistics counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      redirect_valid_r   <= 1'b0;
      redirect_pc_r      <= {ADDR_W{1'b0}};
      branch_count_r     <= {CNT_W{1'b0}};
      mispredict_count_r <= {CNT_W{1'b0}};
    end else begin
      redirect_valid_r <= resolve_s & mispredict_s;
      if (resolve_s & mispredict_s) begin
        redirect_pc_r <= actual_next_s;
      end
      if (resolve_s && (branch_count_r != CNT_MAX)) begin
        branch_count_r <= branch_count_r + CNT_ONE;
      end
      if (resolve_s && mispredict_s && (mispredict_count_r != CNT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + CNT_ONE;
      end
    end
  end

  assign bus.pred_taken       = pred_taken_s;
  assign bus.pred_target      = pred_target_s;
  assign bus.redirect_valid   = redirect_valid_r;
  assign bus.redirect_pc      = redirect_pc_r;
  assign bus.branch_count     = branch_count_r;
  assign bus.mispredict_count = mispredict_count_r;

endmodule
